// File: rtl/branch_rs_if.sv
// Branch reservation station scheduler bus.
//   master : rename/issue side (drives clear, dispatchValid, entryReady, fuStall)
//   slave  : scheduler (drives full, writeRequests, grants, execute, busy, occupancy)
interface branch_rs_if #(
  parameter int ENTRIES = 2,
  parameter int CNT_W   = 2
);
  logic               clear;
  logic               dispatchValid;
  logic [ENTRIES-1:0] entryReady;
  logic               fuStall;
  logic               full;
  logic [ENTRIES-1:0] writeRequests;
  logic [ENTRIES-1:0] grants;
  logic               execute;
  logic [ENTRIES-1:0] busy;
  logic [CNT_W-1:0]   occupancy;

  modport master (
    output clear, dispatchValid, entryReady, fuStall,
    input  full, writeRequests, grants, execute, busy, occupancy
  );

  modport slave (
    input  clear, dispatchValid, entryReady, fuStall,
    output full, writeRequests, grants, execute, busy, occupancy
  );
endinterface

// File: rtl/branch_rs_scheduler.sv
// Allocation/issue controller for the branch reservation station.
// Dispatched branches go to the lowest free entry; each cycle the oldest
// busy entry with ready operands is granted to the branch unit. A
// mispredict clear (or reset) empties the station.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous active-high, clears state and forces outputs idle
//   rs    : branch_rs_if.slave (dispatch/ready/stall/clear in; full,
//           writeRequests, grants, execute, busy, occupancy out)
module branch_rs_scheduler #(
  parameter int ENTRIES = 2,
  parameter int CNT_W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  branch_rs_if.slave   rs
);

  logic [ENTRIES-1:0]              busy_q, busy_d;
  // older_q[i][j] = 1 when entry i was allocated before entry j
  logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;
  logic [CNT_W-1:0]                occ_q, occ_d;

  logic [ENTRIES-1:0] cand, win, free_pick, wr, gr;
  logic               is_full, alloc, issue, found, free_found, hit;

  // selection, allocation and next state
  always_comb begin
    is_full    = &busy_q;
    cand       = busy_q & rs.entryReady;
    win        = '0;
    found      = 1'b0;
    hit        = 1'b0;
    free_pick  = '0;
    free_found = 1'b0;

    // oldest candidate: no other candidate is older than it; first hit by
    // index resolves any tie in favour of the lower entry
    for (int i = 0; i < ENTRIES; i++) begin
      hit = 1'b0;
      for (int j = 0; j < ENTRIES; j++)
        if (cand[j] && older_q[j][i]) hit = 1'b1;
      if (cand[i] && !hit && !found) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end

    for (int i = 0; i < ENTRIES; i++)
      if (!busy_q[i] && !free_found) begin
        free_pick[i] = 1'b1;
        free_found   = 1'b1;
      end

    // allocation looks only at pre-edge busy, so an entry issuing this
    // cycle is not handed out again until the next one
    alloc = rs.dispatchValid & ~is_full & ~rs.clear & ~reset;
    issue = found & ~rs.fuStall & ~rs.clear & ~reset;
    wr    = alloc ? free_pick : '0;
    gr    = issue ? win : '0;

    busy_d  = (busy_q | wr) & ~gr;
    older_d = older_q;
    for (int k = 0; k < ENTRIES; k++)
      if (wr[k])
        for (int j = 0; j < ENTRIES; j++) begin
          older_d[k][j] = 1'b0;
          if (j != k) older_d[j][k] = busy_q[j];
        end
    // issued entry drops out of the age order entirely
    for (int w = 0; w < ENTRIES; w++)
      if (gr[w])
        for (int j = 0; j < ENTRIES; j++) begin
          older_d[w][j] = 1'b0;
          older_d[j][w] = 1'b0;
        end
    occ_d = occ_q + CNT_W'(alloc) - CNT_W'(issue);

    if (reset || rs.clear) begin
      busy_d  = '0;
      older_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      older_q <= '0;
      occ_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      older_q <= older_d;
      occ_q   <= occ_d;
    end
  end

  always_comb begin
    rs.full          = is_full & ~reset;
    rs.writeRequests = wr;
    rs.grants        = gr;
    rs.execute       = |gr;
    rs.busy          = busy_q;
    rs.occupancy     = occ_q;
  end

endmodule
